fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  input  1  SHALL mean: hold the IF/ID outputs (decode not ready).
REQ-005 redirect_valid  input  1  SHALL mean: a taken branch or jump; fetch restarts at redirect_target.
REQ-006 redirect_target  input  32  SHALL be the new fetch address (the sb/uj target from decode).
REQ-007 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-008 imem_addr  output  32  SHALL be the fetch address, word aligned.
REQ-009 imem_gnt  input  1  SHALL mean: the request is accepted this cycle.
REQ-010 imem_rvalid / imem_rdata  input  1 / 32  SHALL be the returned instruction word.
REQ-011 instruction_memory_data  output  32  SHALL be the IF/ID instruction feeding the immediate generator.
REQ-012 program_counter  output  32  SHALL be the address of instruction_memory_data.
REQ-013 if_id_valid  output  1  SHALL mean: the IF/ID contents are a real instruction, not a bubble.

Function
REQ-014 FSM states SHALL be REQ, WAIT, HOLD and DROP, with at most one outstanding request.
REQ-015 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal the fetch pc register.
REQ-016 REQ, gnt=1: latch req_pc <= pc, pc <= pc+4 (mod 2^32, wraps), go to WAIT; gnt=0: stay in REQ.
REQ-017 imem_rvalid SHALL be ignored in REQ and HOLD; it is sampled only in WAIT and DROP, and the memory latency is at least 1 cycle.
REQ-018 WAIT, rvalid=1, stall=0: load IF/ID {imem_rdata, req_pc, valid=1}, go to REQ.
REQ-019 WAIT, rvalid=1, stall=1: capture {imem_rdata, req_pc} in a one-entry hold buffer, go to HOLD.
REQ-020 HOLD, stall=0: move the buffer into IF/ID with valid=1, go to REQ.
REQ-021 When stall=0 and no instruction is loaded that edge, IF/ID SHALL become a bubble: valid=0, instruction 32'h0000_0013 (NOP), program_counter unchanged.
REQ-022 When stall=1 and redirect_valid=0, IF/ID outputs SHALL hold their values.
REQ-023 redirect_valid=1 SHALL have priority over stall and over every FSM transition:
- pc <= {redirect_target[31:2], 2'b00}.
- IF/ID becomes a bubble at that edge (flush).
- The hold buffer is discarded.
REQ-024 Redirect state handling SHALL be:
- REQ with gnt=1: go to DROP.
- REQ with gnt=0: stay in REQ.
- WAIT with rvalid=1: discard the response, go to REQ.
- WAIT with rvalid=0: go to DROP.
- HOLD: go to REQ.
- DROP: stay in DROP.
REQ-025 DROP, rvalid=1 SHALL discard the response, load nothing into IF/ID, and go to REQ.
REQ-026 Instructions SHALL reach IF/ID in program order, with no duplicate and no loss absent a redirect.

Reset
REQ-027 While rst_n=0, outputs SHALL be immediate, independent of clk:
- pc = RESET_PC, state = REQ.
- imem_req = 0.
- instruction_memory_data = 32'h0000_0013.
- program_counter = 0, if_id_valid = 0.
- hold buffer empty.
REQ-028 On the first clk edge after rst_n rises, imem_req SHALL be 1 with imem_addr = RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request, and a late rvalid SHALL be ignored because the state is REQ.

Verification
REQ-030 Reset release, gnt always 1, 1-cycle rvalid with rdata = addr^32'hA5A5_0000 -> IF/ID PCs 0, 4, 8, ..., valid=1, data matching.
REQ-031 Response at pc 0x10 arrives with stall=1 for 3 cycles -> IF/ID holds the previous instruction; 1 cycle after stall drops, program_counter=0x10 with the correct data.
REQ-032 redirect_valid=1 to 0x200 while in WAIT for 0x14 -> the 0x14 response is dropped, the next imem_addr is 0x200, and the next valid IF/ID PC is 0x200.
REQ-033 redirect_target 0x103 together with stall=1 -> imem_addr becomes 0x100 and IF/ID is flushed (valid=0, NOP) despite the stall.
REQ-034 pc 0xFFFF_FFFC granted -> next imem_addr is 0x0000_0000.
REQ-035 rst_n pulsed low between a grant and its rvalid -> outputs reset immediately, the stale rvalid is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// At most one request is outstanding; a response comes back at least one cycle after its grant.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time and fills the IF/ID register.
// A one-entry hold buffer absorbs a response that lands while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          instruction_memory_data,
  output logic [31:0]          program_counter,
  output logic                 if_id_valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_START  = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      state_reg, state_next;
  logic        run_reg;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic [31:0] hold_data_reg, hold_data_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic        valid_reg, valid_next;
  logic        accept;
  logic [31:0] redirect_pc;

  // run_reg keeps imem_req low while reset is held and for the release cycle itself.
  assign imem.imem_req  = run_reg && (state_reg == REQ);
  assign imem.imem_addr = pc_reg;
  assign accept         = imem.imem_req && imem.imem_gnt;
  assign redirect_pc    = redirect_target & ~32'h3;

  assign instruction_memory_data = instr_reg;
  assign program_counter         = pc_out_reg;
  assign if_id_valid             = valid_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_pc_next    = req_pc_reg;
    hold_data_next = hold_data_reg;
    hold_pc_next   = hold_pc_reg;
    instr_next     = instr_reg;
    pc_out_next    = pc_out_reg;
    valid_next     = valid_reg;

    // Without a stall, IF/ID drains to a bubble unless something is loaded below.
    if (!stall) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
    end

    case (state_reg)
      REQ: begin
        if (accept) begin
          req_pc_next = pc_reg;
          pc_next     = pc_reg + 32'd4;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (stall) begin
            hold_data_next = imem.imem_rdata;
            hold_pc_next   = req_pc_reg;
            state_next     = HOLD;
          end else begin
            instr_next  = imem.imem_rdata;
            pc_out_next = req_pc_reg;
            valid_next  = 1'b1;
            state_next  = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_next  = hold_data_reg;
          pc_out_next = hold_pc_reg;
          valid_next  = 1'b1;
          state_next  = REQ;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase

    // A redirect overrides everything above, including a stalled decode.
    if (redirect_valid) begin
      pc_next        = redirect_pc;
      valid_next     = 1'b0;
      instr_next     = NOP_INSTR;
      hold_data_next = 32'h0;
      hold_pc_next   = 32'h0;
      case (state_reg)
        REQ:     state_next = accept ? DROP : REQ;
        WAIT:    state_next = imem.imem_rvalid ? REQ : DROP;
        HOLD:    state_next = REQ;
        DROP:    state_next = DROP;
        default: state_next = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= REQ;
      run_reg       <= 1'b0;
      pc_reg        <= PC_START;
      req_pc_reg    <= 32'h0;
      hold_data_reg <= 32'h0;
      hold_pc_reg   <= 32'h0;
      instr_reg     <= NOP_INSTR;
      pc_out_reg    <= 32'h0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= 1'b1;
      pc_reg        <= pc_next;
      req_pc_reg    <= req_pc_next;
      hold_data_reg <= hold_data_next;
      hold_pc_reg   <= hold_pc_next;
      instr_reg     <= instr_next;
      pc_out_reg    <= pc_out_next;
      valid_reg     <= valid_next;
    end
  end

endmodule
